dot_product_mac: RTL and testbench

//  Streaming signed fixed-point dot-product engine: C = sum(A[k]*B[k]), k = 0..len-1.

---
 rtl/dot_product_mac.sv | 119 +++++++++++
 tb/tb_dot_product_mac.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/dot_product_mac.sv
// rtl/dot_product_mac.sv - streaming signed fixed-point dot-product MAC with saturating result
// Optional build macro: DOT_ROUND_EN (round half toward +inf instead of truncating).
module dot_product_mac #(
  parameter int Q       = 8,
  parameter int N       = 16,
  parameter int MAX_LEN = 16,
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [N-1:0]     i_a,
  input  logic [N-1:0]     i_b,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [N-1:0]     o_c,
  output logic             o_ovr
);

  localparam int ACC_W = 2 * N + $clog2(MAX_LEN);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-N+1){1'b1}}, {(N-1){1'b0}}};
`ifdef DOT_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) << (Q - 1);
`else
  localparam logic signed [ACC_W-1:0] RND = '0;
`endif

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;

  state_t                    state, next_state;
  logic [LEN_W-1:0]          len_q, cnt, len_in;
  logic                      drain_cnt;
  logic                      accept;
  logic                      p_vld;
  logic signed [2*N-1:0]     a_x, b_x, p_q;
  logic signed [ACC_W-1:0]   acc, p_ext, acc_rnd, r_full;
  logic [N-1:0]              sat_c;
  logic                      sat_ovr;

  assign accept = i_valid && i_ready;
  assign len_in = (i_len == '0) ? LEN_W'(1) : i_len;
  assign a_x    = {{N{i_a[N-1]}}, i_a};
  assign b_x    = {{N{i_b[N-1]}}, i_b};
  assign p_ext  = {{(ACC_W-2*N){p_q[2*N-1]}}, p_q};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (accept) next_state = (len_in <= LEN_W'(1)) ? DRAIN : ACC;
      ACC:   if (accept && (LEN_W'(cnt + 1'b1) == len_q)) next_state = DRAIN;
      DRAIN: if (drain_cnt) next_state = DONE;
      DONE:  if (o_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    i_ready = rst_n && ((state == IDLE) || (state == ACC));
    o_valid = (state == DONE);
  end

  // Final scaling and clamp of the full-width accumulator into Qm.Q
  always_comb begin
    acc_rnd = acc + RND;
    r_full  = acc_rnd >>> Q;
    sat_c   = r_full[N-1:0];
    sat_ovr = 1'b0;
    if (r_full > SAT_MAX) begin
      sat_c   = SAT_MAX[N-1:0];
      sat_ovr = 1'b1;
    end else if (r_full < SAT_MIN) begin
      sat_c   = SAT_MIN[N-1:0];
      sat_ovr = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q     <= '0;
      cnt       <= '0;
      drain_cnt <= 1'b0;
      p_vld     <= 1'b0;
      p_q       <= '0;
      acc       <= '0;
      o_c       <= '0;
      o_ovr     <= 1'b0;
    end else begin
      p_vld <= accept;
      if (accept) p_q <= a_x * b_x;

      if (state == DONE && o_ready) acc <= '0;
      else if (p_vld)               acc <= acc + p_ext;

      if (accept && state == IDLE) begin
        len_q <= len_in;
        cnt   <= LEN_W'(1);
      end else if (accept) begin
        cnt <= cnt + 1'b1;
      end

      // Two flush cycles: one for the product stage, one for the accumulate stage
      drain_cnt <= (state == DRAIN) && !drain_cnt;

      if (state == DRAIN && drain_cnt) begin
        o_c   <= sat_c;
        o_ovr <= sat_ovr;
      end
    end
  end

endmodule

// File: tb/tb_dot_product_mac.sv
// tb/tb_dot_product_mac.sv - self-checking bench for dot_product_mac (table vectors + random vs model)
module tb_dot_product_mac;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  i_len;
  logic        i_valid;
  logic        i_ready;
  logic [15:0] i_a, i_b;
  logic        o_valid;
  logic        o_ready;
  logic [15:0] o_c;
  logic        o_ovr;

  int n_vec = 0;
  int n_bad = 0;

  typedef logic [15:0][15:0] vec_t;
  typedef struct packed {
    logic [4:0]  len;
    vec_t        a;
    vec_t        b;
    logic [15:0] c;
    logic        ovr;
    logic [3:0]  stall;
  } vec_rec_t;

  vec_rec_t tbl [10];

  dot_product_mac #(.Q(8), .N(16), .MAX_LEN(16)) dut (
    .clk(clk), .rst_n(rst_n), .i_len(i_len), .i_valid(i_valid), .i_ready(i_ready),
    .i_a(i_a), .i_b(i_b), .o_valid(o_valid), .o_ready(o_ready), .o_c(o_c), .o_ovr(o_ovr)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: exact integer dot product, then scale/round/clamp by plain arithmetic
  function automatic void ref_dot(input logic [4:0] len, input vec_t a, input vec_t b,
                                  output logic [15:0] c, output logic ovr);
    longint s = 0;
    longint r;
    int eff = (len == 0) ? 1 : int'(len);
    for (int k = 0; k < eff; k++) s += longint'($signed(a[k])) * longint'($signed(b[k]));
`ifdef DOT_ROUND_EN
    s += 128;
`endif
    r = s >>> 8;
    ovr = 1'b0;
    if (r > 32767) begin c = 16'h7FFF; ovr = 1'b1; end
    else if (r < -32768) begin c = 16'h8000; ovr = 1'b1; end
    else c = r[15:0];
  endfunction

  function automatic vec_rec_t mk(input logic [4:0] len,
                                  input logic [15:0] a0, a1, a2, a3, b0, b1, b2, b3,
                                  input logic [15:0] c, input logic ovr, input logic [3:0] stall);
    vec_rec_t t = '0;
    t.len = len; t.c = c; t.ovr = ovr; t.stall = stall;
    t.a[0] = a0; t.a[1] = a1; t.a[2] = a2; t.a[3] = a3;
    t.b[0] = b0; t.b[1] = b1; t.b[2] = b2; t.b[3] = b3;
    return t;
  endfunction

  task automatic drive_beats(input logic [4:0] len, input vec_t a, input vec_t b,
                             input bit gaps, input int nbeats, input string tag);
    int k = 0;
    int guard = 0;
    logic v;
    while (k < nbeats && guard < 500) begin
      @(negedge clk);
      guard++;
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      i_valid = v;
      i_len   = (k == 0) ? len : 5'($urandom);
      i_a     = a[k];
      i_b     = b[k];
      if (v && i_ready) k++;
    end
    if (guard >= 500) chk({tag, " beats accepted"}, k, nbeats);
  endtask

  task automatic run_vec(input logic [4:0] len, input vec_t a, input vec_t b,
                         input logic [15:0] exp_c, input logic exp_ovr,
                         input bit gaps, input int stall, input string tag);
    int lat = 0;
    o_ready = (stall == 0);
    drive_beats(len, a, b, gaps, (len == 0) ? 1 : int'(len), tag);
    do begin
      @(negedge clk);
      i_valid = 1'b0;
      i_len   = 5'($urandom);
      lat++;
    end while (!o_valid && lat < 20);
    chk({tag, " latency"}, lat, 3);
    chk({tag, " o_c"}, o_c, exp_c);
    chk({tag, " o_ovr"}, o_ovr, exp_ovr);
    for (int s = 0; s < stall; s++) begin
      i_valid = 1'b1;
      i_a = 16'($urandom);
      i_b = 16'($urandom);
      @(negedge clk);
      chk({tag, " held o_valid"}, o_valid, 1'b1);
      chk({tag, " held o_c"}, o_c, exp_c);
      chk({tag, " stall i_ready"}, i_ready, 1'b0);
    end
    i_valid = 1'b0;
    o_ready = 1'b1;
    @(negedge clk);
    chk({tag, " o_valid after handshake"}, o_valid, 1'b0);
    chk({tag, " i_ready after handshake"}, i_ready, 1'b1);
  endtask

  initial begin
    vec_t ra, rb;
    logic [4:0] rl;
    logic [15:0] rc;
    logic rovr;

    tbl[0] = mk(2, 16'h0180, 16'h0200, 0, 0, 16'h0200, 16'hFF00, 0, 0, 16'h0100, 0, 0);
    tbl[1] = mk(4, 16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00,
                   16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00, 16'h7FFF, 1, 0);
    tbl[2] = mk(4, 16'h8100, 16'h8100, 16'h8100, 16'h8100,
                   16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00, 16'h8000, 1, 0);
`ifdef DOT_ROUND_EN
    tbl[3] = mk(1, 16'h0001, 0, 0, 0, 16'h0080, 0, 0, 0, 16'h0001, 0, 0);
    tbl[4] = mk(1, 16'hFFFF, 0, 0, 0, 16'h0080, 0, 0, 0, 16'h0000, 0, 0);
`else
    tbl[3] = mk(1, 16'h0001, 0, 0, 0, 16'h0080, 0, 0, 0, 16'h0000, 0, 0);
    tbl[4] = mk(1, 16'hFFFF, 0, 0, 0, 16'h0080, 0, 0, 0, 16'hFFFF, 0, 0);
`endif
    tbl[5] = mk(3, 16'h0100, 16'h0100, 16'h0100, 0, 16'h0100, 16'h0100, 16'h0100, 0, 16'h0300, 0, 5);
    tbl[6] = mk(0, 16'h0300, 0, 0, 0, 16'h0200, 0, 0, 0, 16'h0600, 0, 0);
    tbl[7] = mk(2, 16'hFF00, 16'h0080, 0, 0, 16'h0200, 16'hFF00, 0, 0, 16'hFD80, 0, 0);
    tbl[8] = mk(1, 16'h0100, 0, 0, 0, 16'h7FFF, 0, 0, 0, 16'h7FFF, 0, 0);
    tbl[9] = mk(1, 16'h8000, 0, 0, 0, 16'h0100, 0, 0, 0, 16'h8000, 0, 0);

    rst_n = 1'b0; i_valid = 1'b0; i_len = '0; i_a = '0; i_b = '0; o_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset i_ready", i_ready, 1'b0);
    chk("reset o_valid", o_valid, 1'b0);
    chk("reset o_c", o_c, 16'h0000);
    chk("reset o_ovr", o_ovr, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("post-reset i_ready", i_ready, 1'b1);

    for (int i = 0; i < 10; i++)
      run_vec(tbl[i].len, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].ovr, 1'b0,
              int'(tbl[i].stall), $sformatf("tbl%0d", i));

    // Reset in the middle of a vector must discard the partial sum
    ra = '0; rb = '0;
    for (int k = 0; k < 16; k++) begin ra[k] = 16'h4000; rb[k] = 16'h0400; end
    o_ready = 1'b1;
    drive_beats(8, ra, rb, 1'b0, 3, "midreset");
    @(negedge clk);
    i_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset o_valid", o_valid, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("midreset i_ready", i_ready, 1'b1);
    run_vec(tbl[0].len, tbl[0].a, tbl[0].b, 16'h0100, 1'b0, 1'b0, 0, "after-reset");

    for (int i = 0; i < 24; i++) begin
      rl = (i == 0) ? 5'd16 : 5'($urandom_range(0, 16));
      for (int k = 0; k < 16; k++) begin
        ra[k] = (i % 3 == 0) ? 16'($urandom) : 16'($signed(10'($urandom)));
        rb[k] = (i % 3 == 0) ? 16'($urandom) : 16'($signed(11'($urandom)));
      end
      ref_dot(rl, ra, rb, rc, rovr);
      run_vec(rl, ra, rb, rc, rovr, 1'b1, $urandom_range(0, 3), $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
